// File: rtl/glove_tracker.sv
// glove_tracker: glove position filter, closed-bit debounce and catch cooldown; define GLOVE_TRK_STATS_EN to build the rejected-sample counter
module glove_tracker #(
  parameter int GLOVE_ID        = 1,
  parameter int AVG_LOG2        = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int COOLDOWN_CYCLES = 8437500,
  parameter int MAX_MM          = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic        raw_closed,
  input  logic [1:0]  ball_state,
  output logic [15:0] glove_x,
  output logic [15:0] glove_y,
  output logic        pos_valid,
  output logic        glove_closed,
  output logic        can_catch,
  output logic [7:0]  reject_count
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [15:0] MAX_V = 16'(MAX_MM);
  typedef enum logic [1:0] {READY, HOLDING, COOLDOWN} state_t;
  logic          accept, held, sync_a, sync_b;
  logic [15:0]   hist_x [N];
  logic [15:0]   hist_y [N];
  logic [SW-1:0] sum_x, sum_y, nsum_x, nsum_y;
  logic [DW-1:0] db_cnt;
  logic [CW-1:0] cd_cnt, ncd_cnt;
  state_t        st, nst;
  assign accept = sample_valid && sample_x <= MAX_V && sample_y <= MAX_V;
  assign held   = ball_state == 2'(GLOVE_ID);
  assign nsum_x = pos_valid ? sum_x + SW'(sample_x) - SW'(hist_x[N-1]) : SW'(sample_x) << AVG_LOG2;
  assign nsum_y = pos_valid ? sum_y + SW'(sample_y) - SW'(hist_y[N-1]) : SW'(sample_y) << AVG_LOG2;
  // moving-average filter: first sample fills the whole history, later ones slide it
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_x     <= '0;
      sum_y     <= '0;
      glove_x   <= '0;
      glove_y   <= '0;
      pos_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
      end
    end else if (accept) begin
      sum_x     <= nsum_x;
      sum_y     <= nsum_y;
      glove_x   <= 16'(nsum_x >> AVG_LOG2);
      glove_y   <= 16'(nsum_y >> AVG_LOG2);
      pos_valid <= 1'b1;
      hist_x[0] <= sample_x;
      hist_y[0] <= sample_y;
      for (int i = 1; i < N; i++) begin
        hist_x[i] <= pos_valid ? hist_x[i-1] : sample_x;
        hist_y[i] <= pos_valid ? hist_y[i-1] : sample_y;
      end
    end
  end
  // synchronise the fist bit and accept a new level only after it has held long enough
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a       <= 1'b0;
      sync_b       <= 1'b0;
      db_cnt       <= '0;
      glove_closed <= 1'b0;
    end else begin
      sync_a <= raw_closed;
      sync_b <= sync_a;
      if (sync_b == glove_closed) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        glove_closed <= sync_b;
        db_cnt       <= '0;
      end else db_cnt <= db_cnt + DW'(1);
    end
  end
  // cooldown state register; can_catch follows the next state so it is glitch-free
  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= READY;
      cd_cnt    <= '0;
      can_catch <= 1'b1;
    end else begin
      st        <= nst;
      cd_cnt    <= ncd_cnt;
      can_catch <= nst != COOLDOWN;
    end
  end
  // cooldown next state: a respawn into this glove beats cooldown expiry
  always_comb begin
    nst     = st;
    ncd_cnt = cd_cnt;
    case (st)
      READY:   nst = held ? HOLDING : READY;
      HOLDING: begin
        nst     = held ? HOLDING : COOLDOWN;
        ncd_cnt = held ? cd_cnt : CW'(COOLDOWN_CYCLES - 1);
      end
      COOLDOWN: begin
        ncd_cnt = cd_cnt - CW'(1);
        nst     = held ? HOLDING : (cd_cnt == '0 ? READY : COOLDOWN);
      end
      default: nst = READY;
    endcase
  end
`ifdef GLOVE_TRK_STATS_EN
  // saturating count of out-of-range samples
  always_ff @(posedge clk) begin
    if (!reset) reject_count <= '0;
    else if (sample_valid && !accept && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
  end
`else
  assign reject_count = '0;
`endif
endmodule
